// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-op bit positions
// and the packed layout of the EX->MEM payload.
package mem_stage_pkg;

    localparam int ES2MS_BUS_LEN  = 76;
    localparam int MS2WS_BUS_LEN  = 70;
    localparam int MS_FWD_BUS_LEN = 38;

    // Bit positions inside the one-hot ld_op field {ld_w, ld_h, ld_hu, ld_b, ld_bu}
    localparam int LD_BU = 0;
    localparam int LD_B  = 1;
    localparam int LD_HU = 2;
    localparam int LD_H  = 3;
    localparam int LD_W  = 4;

    // EX->MEM payload, MSB first, matching the es2ms_bus packing
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic [4:0]  ld_op;
    } es2ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: picks the addressed byte/half/word out of a 32-bit read
// word and sign- or zero-extends it. Purely combinational so that a later
// cache refill path can reuse it unchanged.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_sel,
    input  logic [4:0]  i_ld_op,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half-word; half ignores sel[0]
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_sel)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_sel[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend according to the one-hot op; anything not one-hot reads as zero
    always_comb begin
        o_load_data = 32'h0;
        case (i_ld_op)
            5'b00001 << LD_W:  o_load_data = i_rdata;
            5'b00001 << LD_H:  o_load_data = {{16{w_half[15]}}, w_half};
            5'b00001 << LD_HU: o_load_data = {16'h0, w_half};
            5'b00001 << LD_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            5'b00001 << LD_BU: o_load_data = {24'h0, w_byte};
            default:           o_load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline. Latches the EX result,
// aligns load data from the synchronous data SRAM and presents the result
// to WB and to the ID bypass network.
// Optional feature macro: MS_LOAD_HOLD_EN keeps a copy of the SRAM word so
// loads survive WB stalls; without it WB must never stall a load.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      es2ms_valid,
    output logic                      ms_allowin,
    input  logic [ES2MS_BUS_LEN-1:0]  es2ms_bus,
    input  logic                      ws_allowin,
    output logic                      ms2ws_valid,
    output logic [MS2WS_BUS_LEN-1:0]  ms2ws_bus,
    input  logic [31:0]               data_sram_rdata,
    output logic [MS_FWD_BUS_LEN-1:0] ms_fwd_bus
);

    logic        r_ms_valid;
    logic        r_ms_first;
    es2ms_t      r_payload;

    logic        w_ms_ready_go;
    logic        w_capture;
    logic        w_handoff;
    logic [31:0] w_load_src;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic        w_fwd_we;

    assign w_ms_ready_go = 1'b1;
    assign ms_allowin    = ~r_ms_valid | (w_ms_ready_go & ws_allowin);
    assign ms2ws_valid   = r_ms_valid & w_ms_ready_go;
    assign w_capture     = es2ms_valid & ms_allowin;
    assign w_handoff     = ms2ws_valid & ws_allowin;

    // Stage occupancy: refilled from EX whenever MEM can accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es2ms_valid;
        end
    end

    // Payload latch; intentionally not reset since r_ms_valid qualifies it
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_payload <= es2ms_t'(es2ms_bus);
        end
    end

    // Marks the single cycle in which the SRAM read data belongs to us
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_first <= 1'b0;
        end else if (w_capture) begin
            r_ms_first <= 1'b1;
        end else if (r_ms_valid) begin
            r_ms_first <= 1'b0;
        end
    end

`ifdef MS_LOAD_HOLD_EN
    logic [31:0] r_hold_data;
    logic        r_hold_vld;

    // Snapshot the SRAM word in the first cycle of a load so stalls are safe
    always_ff @(posedge clk) begin
        if (r_ms_valid && r_ms_first && r_payload.res_from_mem) begin
            r_hold_data <= data_sram_rdata;
        end
    end

    // Hold-valid flag follows the load until it leaves for WB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_vld <= 1'b0;
        end else if (w_handoff && !w_capture) begin
            r_hold_vld <= 1'b0;
        end else if (r_ms_valid && r_ms_first && r_payload.res_from_mem) begin
            r_hold_vld <= 1'b1;
        end
    end

    assign w_load_src = r_ms_first ? data_sram_rdata
                                   : (r_hold_vld ? r_hold_data : 32'h0);
`else
    assign w_load_src = data_sram_rdata;
`endif

    load_align u_load_align (
        .i_rdata     (w_load_src),
        .i_sel       (r_payload.alu_result[1:0]),
        .i_ld_op     (r_payload.ld_op),
        .o_load_data (w_load_data)
    );

    assign w_final_result = r_payload.res_from_mem ? w_load_data : r_payload.alu_result;
    assign w_fwd_we       = r_ms_valid & r_payload.gr_we & (r_payload.dest != 5'd0);

    assign ms2ws_bus  = {r_payload.pc, r_payload.gr_we, r_payload.dest, w_final_result};
    assign ms_fwd_bus = {w_fwd_we, r_payload.dest, w_final_result};

endmodule
